immgen_pipe: RTL and testbench

//  Parametrised, registered successor of the combinational immediate generator.

---
 rtl/immgen_pipe_if.sv | 27 ++
 rtl/immgen_pipe.sv | 114 +++++++++++
 tb/tb_immgen_pipe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/immgen_pipe_if.sv
// Handshake bundle for the registered immediate generator.
// slave is the generator's view, master is the driver/consumer view.
interface immgen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       imm_sel;
  logic [24:0]      inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, imm_sel, inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, imm_sel, inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/immgen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer.
// Output register plus one skid slot keep decode at full rate under stalls.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  immgen_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } beat_t;

  state_t state_q, state_d;
  beat_t  in_beat, or_q, sk_q;
  logic   acc, drn;
  logic   load_or, load_sk, sk_to_or;

  logic signed [31:0] imm32;
  logic               ill;
  logic [24:0]        i;

  // i[k] holds instruction bit k+7
  always_comb begin
    i     = bus.inst;
    imm32 = '0;
    ill   = 1'b0;
    unique case (bus.imm_sel)
      3'd0: imm32 = {{20{i[24]}}, i[24:13]};
      3'd1: imm32 = {{20{i[24]}}, i[24:18], i[4:0]};
      3'd2: imm32 = {{20{i[24]}}, i[0], i[23:18],
                     i[4:1], 1'b0};
      3'd3: imm32 = {i[24:5], 12'b0};
      3'd4: imm32 = {{12{i[24]}}, i[12:5], i[13],
                     i[23:14], 1'b0};
      3'd5: imm32 = {27'b0, i[12:8]};
      3'd6: imm32 = (XLEN == 64) ? {26'b0, i[18:13]}
                                 : {27'b0, i[17:13]};
      default: ill = 1'b1;
    endcase
  end

  assign in_beat.imm = XLEN'(imm32);
  assign in_beat.tag = bus.in_tag;
  assign in_beat.err = ill;

  assign acc = bus.in_valid & (state_q != TWO);
  assign drn = (state_q != EMPTY) & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_or  = 1'b0;
    load_sk  = 1'b0;
    sk_to_or = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          load_or = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && drn) begin
          load_or = 1'b1;
        end else if (acc) begin
          load_sk = 1'b1;
          state_d = TWO;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drn) begin
          sk_to_or = 1'b1;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      if (load_or)       or_q <= in_beat;
      else if (sk_to_or) or_q <= sk_q;
      if (load_sk)       sk_q <= in_beat;
    end
  end

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_imm   = or_q.imm;
  assign bus.out_tag   = or_q.tag;
  assign bus.out_err   = or_q.err & bus.out_valid;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
// A queue-based reference model predicts occupancy and every output beat.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  sel;
  logic [31:0] ins;
  logic [4:0]  tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  immgen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  immgen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.imm_sel   = sel;
  assign b32.inst      = ins[31:7];
  assign b32.in_tag    = tag;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.imm_sel   = sel;
  assign b64.inst      = ins[31:7];
  assign b64.in_tag    = tag;
  assign b64.out_ready = out_ready;

  immgen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .bus(b32.slave)
  );
  immgen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .bus(b64.slave)
  );

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] ins;
    logic [4:0]  tag;
  } beat_t;

  beat_t q[$];
  logic  acc_seen = 1'b0;

  function automatic logic [63:0] sext(input logic [63:0] v,
                                       input int bits);
    if (v[bits-1]) return v - (64'd1 << bits);
    return v;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [2:0] s,
                                          input logic [31:0] w,
                                          input int xlen);
    logic [63:0] x, v;
    x = {32'b0, w};
    case (s)
      3'd0: v = sext(x >> 20, 12);
      3'd1: v = sext(((x >> 25) << 5) | ((x >> 7) & 31), 12);
      3'd2: v = sext((((x >> 31) & 1) << 12) |
                     (((x >> 7) & 1) << 11) |
                     (((x >> 25) & 63) << 5) |
                     (((x >> 8) & 15) << 1), 13);
      3'd3: v = sext(x & 64'hFFFF_F000, 32);
      3'd4: v = sext((((x >> 31) & 1) << 20) |
                     (((x >> 12) & 255) << 12) |
                     (((x >> 20) & 1) << 11) |
                     (((x >> 21) & 1023) << 1), 21);
      3'd5: v = (x >> 15) & 31;
      3'd6: v = (x >> 20) & ((xlen == 64) ? 63 : 31);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  always @(negedge clk) begin
    int sz;
    if (rst) begin
      q.delete();
      acc_seen = 1'b0;
      chk("rst_vld32", b32.out_valid, 0);
      chk("rst_rdy64", b64.in_ready, 1);
      chk("rst_imm64", b64.out_imm, 0);
      chk("rst_tag32", b32.out_tag, 0);
      chk("rst_err32", b32.out_err, 0);
    end else begin
      sz = q.size();
      chk("vld32", b32.out_valid, sz > 0);
      chk("vld64", b64.out_valid, sz > 0);
      chk("rdy32", b32.in_ready, sz < 2);
      chk("rdy64", b64.in_ready, sz < 2);
      if (sz > 0) begin
        chk("imm32", b32.out_imm, ref_imm(q[0].sel, q[0].ins, 32));
        chk("imm64", b64.out_imm, ref_imm(q[0].sel, q[0].ins, 64));
        chk("tag32", b32.out_tag, q[0].tag);
        chk("tag64", b64.out_tag, q[0].tag);
        chk("err32", b32.out_err, q[0].sel == 3'd7);
        chk("err64", b64.out_err, q[0].sel == 3'd7);
      end else begin
        chk("idle_err32", b32.out_err, 0);
        chk("idle_err64", b64.out_err, 0);
      end
      if (sz > 0 && out_ready) void'(q.pop_front());
      acc_seen = in_valid && (sz < 2);
      if (acc_seen) q.push_back('{sel, ins, tag});
    end
  end

  task automatic drive(input logic [2:0] s, input logic [31:0] w,
                       input logic [4:0] t);
    @(posedge clk); #1;
    sel = s; ins = w; tag = t; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b32.in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("acc_timeout", b32.in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] s,
                          input logic [31:0] w,
                          input logic [63:0] e32,
                          input logic [63:0] e64);
    drive(s, w, 5'd7);
    @(negedge clk);
    chk({name, "_32"}, b32.out_imm, e32);
    chk({name, "_64"}, b64.out_imm, e64);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sel = '0; ins = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    directed("I", 3'd0, 32'hFFF0_0093,
             64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    directed("S", 3'd1, 32'hFE20_AE23,
             64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    directed("B", 3'd2, 32'hFE00_0EE3,
             64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    directed("U", 3'd3, 32'h8000_00B7,
             64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    directed("J", 3'd4, 32'h0000_006F, 64'h0, 64'h0);
    directed("Z", 3'd5, 32'd31 << 15, 64'h1F, 64'h1F);
    directed("SH", 3'd6, 32'd63 << 20, 64'h1F, 64'h3F);
    directed("ILL", 3'd7, 32'hFFFF_FFFF, 64'h0, 64'h0);
    chk("ill_err32", b32.out_err, 1);
    chk("ill_err64", b64.out_err, 1);

    // back-to-back beats into a stalled consumer
    @(posedge clk); #1;
    out_ready = 1'b0;
    sel = 3'd0; ins = 32'h0010_0000; tag = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1 tag = 5'd2;
    @(posedge clk); #1 tag = 5'd3;
    @(negedge clk);
    chk("bp_rdy", b32.in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_tag1", b32.out_tag, 1);
    @(negedge clk);
    chk("bp_tag2", b32.out_tag, 2);
    chk("bp_rdy2", b32.in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_tag3", b64.out_tag, 3);

    // reset while both entries are occupied
    @(posedge clk); #1;
    out_ready = 1'b0;
    sel = 3'd5; ins = 32'hFFFF_FFFF; tag = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1 tag = 5'd10;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_rdy", b32.in_ready, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_vld", b64.out_valid, 0);
    chk("arst_rdy", b32.in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    directed("POST", 3'd5, 32'd21 << 15, 64'h15, 64'h15);

    // randomized traffic with valid held until accepted
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_seen) begin
        in_valid = ($urandom % 4) != 0;
        sel = 3'($urandom_range(0, 7));
        ins = $urandom;
        tag = 5'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("end_idle32", b32.out_valid, 0);
    chk("end_idle64", b64.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
